// File: rtl/gl_pixel_writer.sv
// gl_pixel_writer: drains the rasterizer's pixel-fragment FIFO one word at a time.
// Each fragment is unpacked into x, y and 6/6/6 RGB. Its linear address in the current back
// buffer is computed, and one write per fragment is issued over a req/ack framebuffer port.
// The all-ones flush word swaps front/back buffers and pulses frame_done.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   fifo_empty    pixel FIFO empty flag
//   fifo_rd_en    FIFO pop strobe (only ever in idle, never when empty)
//   fifo_rd_data  FIFO word, valid the cycle after fifo_rd_en (non-FWFT)
//   fb_wr_en      framebuffer write request, held until fb_ack
//   fb_addr       framebuffer word address
//   fb_data       pixel data {r[5:0], g[5:0], b[5:0]}
//   fb_ack        framebuffer accepts the write this cycle
//   front_buf     buffer being scanned out; writes target !front_buf
//   frame_done    one-cycle pulse when a flush word is processed
//   pixel_count   fragments written in the current frame
//   drop_count    out-of-range fragments discarded since reset (saturating)
module gl_pixel_writer #(
  parameter int unsigned H_RES    = 640,
  parameter int unsigned V_RES    = 480,
  parameter int unsigned COL_LEN  = 10,
  parameter int unsigned LINE_LEN = 9,
  parameter int unsigned ADDR_W   = 20,
  parameter int unsigned BUF_SIZE = H_RES * V_RES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [95:0]       fifo_rd_data,
  output logic              fb_wr_en,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [17:0]       fb_data,
  input  logic              fb_ack,
  output logic              front_buf,
  output logic              frame_done,
  output logic [19:0]       pixel_count,
  output logic [15:0]       drop_count
);

  typedef enum logic [1:0] {StIdle, StFetch, StWrite, StFlush} state_e;

  localparam logic [ADDR_W-1:0] HResW    = ADDR_W'(H_RES);
  localparam logic [ADDR_W-1:0] BufBaseW = ADDR_W'(BUF_SIZE);

  state_e            state_q, state_d;
  logic              front_q, front_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [17:0]       data_q, data_d;
  logic [19:0]       pix_q, pix_d;
  logic [15:0]       drop_q, drop_d;

  // Fragment decode, meaningful only in StFetch when fifo_rd_data is valid
  logic [COL_LEN-1:0]  frag_x;
  logic [LINE_LEN-1:0] frag_y;
  logic [17:0]         frag_rgb;
  logic                is_flush;
  logic                in_range;
  logic [ADDR_W-1:0]   line_off;
  logic [ADDR_W-1:0]   frag_addr;

  always_comb begin
    frag_x    = fifo_rd_data[64 +: COL_LEN];
    frag_y    = fifo_rd_data[80 +: LINE_LEN];
    frag_rgb  = {fifo_rd_data[55:50], fifo_rd_data[47:42], fifo_rd_data[39:34]};
    is_flush  = &fifo_rd_data;
    in_range  = (32'(frag_x) < H_RES) && (32'(frag_y) < V_RES);
    line_off  = ADDR_W'(frag_y) * HResW;
    // Back buffer is the one not on display: buffer 1 lives at BUF_SIZE
    frag_addr = (front_q ? '0 : BufBaseW) + line_off + ADDR_W'(frag_x);
  end

  always_comb begin
    state_d    = state_q;
    front_d    = front_q;
    addr_d     = addr_q;
    data_d     = data_q;
    pix_d      = pix_q;
    drop_d     = drop_q;
    fifo_rd_en = 1'b0;
    fb_wr_en   = 1'b0;
    frame_done = 1'b0;

    case (state_q)
      StIdle: begin
        // Gated by rst so a word is never popped into a block that is resetting
        if (!fifo_empty && !rst) begin
          fifo_rd_en = 1'b1;
          state_d    = StFetch;
        end
      end
      StFetch: begin
        if (is_flush) begin
          state_d = StFlush;
        end else if (!in_range) begin
          if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
          state_d = StIdle;
        end else begin
          addr_d  = frag_addr;
          data_d  = frag_rgb;
          state_d = StWrite;
        end
      end
      StWrite: begin
        fb_wr_en = 1'b1;
        if (fb_ack) begin
          pix_d   = pix_q + 20'd1;
          state_d = StIdle;
        end
      end
      StFlush: begin
        front_d    = ~front_q;
        frame_done = 1'b1;
        pix_d      = '0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      front_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      pix_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      front_q <= front_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      pix_q   <= pix_d;
      drop_q  <= drop_d;
    end
  end

  assign fb_addr     = addr_q;
  assign fb_data     = data_q;
  assign front_buf   = front_q;
  assign pixel_count = pix_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_gl_pixel_writer.sv
// Directed bench for gl_pixel_writer: a queue-backed non-FWFT FIFO model feeds fragments;
// every write handshake, pop and frame_done cycle is logged with its cycle number.
module tb_gl_pixel_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [95:0] fifo_rd_data;
  logic        fb_wr_en;
  logic [19:0] fb_addr;
  logic [17:0] fb_data;
  logic        fb_ack;
  logic        front_buf;
  logic        frame_done;
  logic [19:0] pixel_count;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  gl_pixel_writer dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fb_wr_en     (fb_wr_en),
    .fb_addr      (fb_addr),
    .fb_data      (fb_data),
    .fb_ack       (fb_ack),
    .front_buf    (front_buf),
    .frame_done   (frame_done),
    .pixel_count  (pixel_count),
    .drop_count   (drop_count)
  );

  logic [95:0] q[$];
  bit          hold_empty;
  int          cyc;
  int          n_cmp;
  int          n_err;
  int          n_done;
  int          bad_pop;
  int          pop_cyc[$];
  int          wr_cyc[$];
  logic [19:0] wr_addr[$];
  logic [17:0] wr_data[$];

  function automatic logic [95:0] frag(input int x, input int y, input logic [5:0] r,
                                       input logic [5:0] g, input logic [5:0] b);
    logic [95:0] w;
    w        = '0;
    w[88:80] = y[8:0];
    w[73:64] = x[9:0];
    w[55:50] = r;
    w[47:42] = g;
    w[39:34] = b;
    return w;
  endfunction

  task automatic update_empty();
    fifo_empty = hold_empty || (q.size() == 0);
  endtask

  task automatic push(input logic [95:0] w);
    q.push_back(w);
    update_empty();
  endtask

  task automatic clear_log();
    pop_cyc.delete();
    wr_cyc.delete();
    wr_addr.delete();
    wr_data.delete();
    n_done = 0;
  endtask

  // One clock: log DUT outputs at the falling edge, then model the FIFO read after the rise.
  task automatic tick();
    bit pop_now;
    @(negedge clk);
    pop_now = (fifo_rd_en === 1'b1);
    if (pop_now) begin
      pop_cyc.push_back(cyc);
      if (fifo_empty !== 1'b0) bad_pop++;
    end
    if (fb_wr_en === 1'b1 && fb_ack === 1'b1) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(fb_addr);
      wr_data.push_back(fb_data);
    end
    if (frame_done === 1'b1) n_done++;
    @(posedge clk);
    #1;
    cyc++;
    if (pop_now && q.size() > 0) fifo_rd_data = q.pop_front();
    update_empty();
  endtask

  task automatic run_until_writes(input int n, input int budget);
    for (int i = 0; i < budget && wr_cyc.size() < n; i++) tick();
  endtask

  task automatic wait_wr_en(input int budget);
    for (int i = 0; i < budget && fb_wr_en !== 1'b1; i++) tick();
  endtask

  function automatic logic [19:0] addr_at(input int i);
    return (wr_addr.size() > i) ? wr_addr[i] : 20'hxxxxx;
  endfunction

  function automatic logic [17:0] data_at(input int i);
    return (wr_data.size() > i) ? wr_data[i] : 18'hxxxxx;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({fifo_rd_en, fb_wr_en, frame_done, front_buf} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got rd_en/wr_en/done/front=%b want 0000",
               {fifo_rd_en, fb_wr_en, frame_done, front_buf});
    end
    n_cmp++;
    if ({fb_addr, fb_data} !== 38'd0) begin
      n_err++;
      $display("FAIL reset_fb: got addr=%0d data=%h want 0/0", fb_addr, fb_data);
    end
    n_cmp++;
    if ({pixel_count, drop_count} !== 36'd0) begin
      n_err++;
      $display("FAIL reset_counts: got pix=%0d drop=%0d want 0/0", pixel_count, drop_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int lat;
    clear_log();
    fb_ack = 1'b1;
    push(frag(5, 2, 6'h3F, 6'h00, 6'h15));
    run_until_writes(1, 20);
    tick();
    n_cmp++;
    if (wr_cyc.size() !== 1) begin
      n_err++;
      $display("FAIL single_count: got %0d writes want 1", wr_cyc.size());
    end
    n_cmp++;
    if (addr_at(0) !== 20'd308485) begin
      n_err++;
      $display("FAIL single_addr: got %0d want 308485", addr_at(0));
    end
    n_cmp++;
    if (data_at(0) !== 18'h3F015) begin
      n_err++;
      $display("FAIL single_data: got %h want 3f015", data_at(0));
    end
    lat = (wr_cyc.size() > 0 && pop_cyc.size() > 0) ? wr_cyc[0] - pop_cyc[0] : -1;
    n_cmp++;
    if (lat !== 2) begin
      n_err++;
      $display("FAIL single_latency: got %0d cycles pop->write want 2", lat);
    end
    n_cmp++;
    if (pixel_count !== 20'd1) begin
      n_err++;
      $display("FAIL single_pixcount: got %0d want 1", pixel_count);
    end
  endtask

  task automatic test_back_to_back();
    int gap;
    clear_log();
    fb_ack = 1'b1;
    push(frag(7, 0, 6'h01, 6'h01, 6'h01));
    push(frag(8, 0, 6'h02, 6'h02, 6'h02));
    run_until_writes(2, 30);
    tick();
    gap = (pop_cyc.size() > 1) ? pop_cyc[1] - pop_cyc[0] : -1;
    n_cmp++;
    if (gap !== 3) begin
      n_err++;
      $display("FAIL b2b_gap: got %0d cycles between pops want 3", gap);
    end
    n_cmp++;
    if ({addr_at(0), addr_at(1)} !== {20'd307207, 20'd307208}) begin
      n_err++;
      $display("FAIL b2b_addr: got %0d,%0d want 307207,307208", addr_at(0), addr_at(1));
    end
    n_cmp++;
    if ({data_at(0), data_at(1)} !== {18'h01041, 18'h02082}) begin
      n_err++;
      $display("FAIL b2b_data: got %h,%h want 01041,02082", data_at(0), data_at(1));
    end
    n_cmp++;
    if (pixel_count !== 20'd3) begin
      n_err++;
      $display("FAIL b2b_pixcount: got %0d want 3", pixel_count);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    clear_log();
    fb_ack = 1'b0;
    push(frag(10, 3, 6'h01, 6'h02, 6'h03));
    push(frag(11, 3, 6'h00, 6'h00, 6'h01));
    wait_wr_en(20);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (fb_wr_en !== 1'b1 || fb_addr !== 20'd309130 || fb_data !== 18'h01083) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL bp_stable: got %0d unstable stall cycles want 0", bad);
    end
    n_cmp++;
    if (pop_cyc.size() !== 1) begin
      n_err++;
      $display("FAIL bp_no_pop: got %0d pops during stall want 1", pop_cyc.size());
    end
    fb_ack = 1'b1;
    run_until_writes(2, 30);
    tick();
    n_cmp++;
    if ({addr_at(0), addr_at(1)} !== {20'd309130, 20'd309131}) begin
      n_err++;
      $display("FAIL bp_addr: got %0d,%0d want 309130,309131", addr_at(0), addr_at(1));
    end
    n_cmp++;
    if (wr_cyc.size() !== 2 || pixel_count !== 20'd5) begin
      n_err++;
      $display("FAIL bp_count: got writes=%0d pix=%0d want 2/5", wr_cyc.size(), pixel_count);
    end
  endtask

  task automatic test_bounds();
    clear_log();
    fb_ack = 1'b1;
    push(frag(639, 479, 6'h3F, 6'h3F, 6'h3F));
    push(frag(640, 0, 6'h3F, 6'h3F, 6'h3F));
    push(frag(0, 480, 6'h3F, 6'h3F, 6'h3F));
    run_until_writes(1, 20);
    for (int i = 0; i < 12; i++) tick();
    n_cmp++;
    if (wr_cyc.size() !== 1 || addr_at(0) !== 20'd614399) begin
      n_err++;
      $display("FAIL bounds_write: got writes=%0d addr=%0d want 1/614399",
               wr_cyc.size(), addr_at(0));
    end
    n_cmp++;
    if (data_at(0) !== 18'h3FFFF) begin
      n_err++;
      $display("FAIL bounds_data: got %h want 3ffff", data_at(0));
    end
    n_cmp++;
    if (drop_count !== 16'd2 || pop_cyc.size() !== 3) begin
      n_err++;
      $display("FAIL bounds_drop: got drop=%0d pops=%0d want 2/3", drop_count, pop_cyc.size());
    end
  endtask

  task automatic test_fifo_empty();
    clear_log();
    fb_ack = 1'b1;
    hold_empty = 1'b1;
    push(frag(1, 1, 6'h00, 6'h00, 6'h00));
    push(frag(2, 1, 6'h00, 6'h00, 6'h00));
    for (int i = 0; i < 20; i++) tick();
    n_cmp++;
    if (pop_cyc.size() !== 0) begin
      n_err++;
      $display("FAIL empty_hold: got %0d pops while empty want 0", pop_cyc.size());
    end
    hold_empty = 1'b0;
    update_empty();
    tick();
    tick();
    n_cmp++;
    if (pop_cyc.size() !== 1) begin
      n_err++;
      $display("FAIL empty_pulse: got %0d pops in 2 cycles want 1", pop_cyc.size());
    end
    run_until_writes(2, 20);
    tick();
    n_cmp++;
    if ({addr_at(0), addr_at(1)} !== {20'd307841, 20'd307842} || pixel_count !== 20'd8) begin
      n_err++;
      $display("FAIL empty_writes: got %0d,%0d pix=%0d want 307841,307842 pix=8",
               addr_at(0), addr_at(1), pixel_count);
    end
  endtask

  task automatic test_flush();
    logic [95:0] flush_w;
    flush_w = '1;
    clear_log();
    fb_ack = 1'b1;
    push(frag(0, 0, 6'h01, 6'h00, 6'h00));
    push(frag(1, 0, 6'h02, 6'h00, 6'h00));
    push(frag(639, 1, 6'h03, 6'h00, 6'h00));
    push(flush_w);
    for (int i = 0; i < 40 && n_done < 1; i++) tick();
    for (int i = 0; i < 3; i++) tick();
    n_cmp++;
    if (wr_cyc.size() !== 3 || addr_at(0) !== 20'd307200 || addr_at(2) !== 20'd308479) begin
      n_err++;
      $display("FAIL flush_writes: got n=%0d a0=%0d a2=%0d want 3/307200/308479",
               wr_cyc.size(), addr_at(0), addr_at(2));
    end
    n_cmp++;
    if (n_done !== 1 || front_buf !== 1'b1 || pixel_count !== 20'd0) begin
      n_err++;
      $display("FAIL flush_state: got done_cycles=%0d front=%b pix=%0d want 1/1/0",
               n_done, front_buf, pixel_count);
    end
    clear_log();
    push(frag(0, 0, 6'h2A, 6'h00, 6'h00));
    run_until_writes(1, 20);
    n_cmp++;
    if (addr_at(0) !== 20'd0 || data_at(0) !== 18'h2A000) begin
      n_err++;
      $display("FAIL flush_buf0: got addr=%0d data=%h want 0/2a000", addr_at(0), data_at(0));
    end
    clear_log();
    push(flush_w);
    push(flush_w);
    for (int i = 0; i < 12; i++) tick();
    n_cmp++;
    if (n_done !== 2 || front_buf !== 1'b1 || pixel_count !== 20'd0) begin
      n_err++;
      $display("FAIL flush_b2b: got done_cycles=%0d front=%b pix=%0d want 2/1/0",
               n_done, front_buf, pixel_count);
    end
  endtask

  task automatic test_reset_in_write();
    clear_log();
    fb_ack = 1'b0;
    push(frag(20, 4, 6'h01, 6'h00, 6'h00));
    wait_wr_en(20);
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({fifo_rd_en, fb_wr_en, frame_done, fb_addr, fb_data} !== 41'd0) begin
      n_err++;
      $display("FAIL rstw_outputs: got rd=%b wr=%b done=%b addr=%0d data=%h want all 0",
               fifo_rd_en, fb_wr_en, frame_done, fb_addr, fb_data);
    end
    n_cmp++;
    if ({front_buf, pixel_count, drop_count} !== 37'd0) begin
      n_err++;
      $display("FAIL rstw_state: got front=%b pix=%0d drop=%0d want 0/0/0",
               front_buf, pixel_count, drop_count);
    end
    rst = 1'b0;
    n_cmp++;
    if (wr_cyc.size() !== 0) begin
      n_err++;
      $display("FAIL rstw_nowrite: got %0d writes want 0", wr_cyc.size());
    end
    clear_log();
    fb_ack = 1'b1;
    push(frag(5, 2, 6'h3F, 6'h00, 6'h15));
    run_until_writes(1, 20);
    tick();
    n_cmp++;
    if (addr_at(0) !== 20'd308485 || pixel_count !== 20'd1) begin
      n_err++;
      $display("FAIL rstw_resume: got addr=%0d pix=%0d want 308485/1", addr_at(0), pixel_count);
    end
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    cyc          = 0;
    bad_pop      = 0;
    n_done       = 0;
    hold_empty   = 1'b0;
    fb_ack       = 1'b0;
    rst          = 1'b1;
    fifo_rd_data = '0;
    update_empty();

    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_bounds();
    test_fifo_empty();
    test_flush();
    test_reset_in_write();

    n_cmp++;
    if (bad_pop !== 0) begin
      n_err++;
      $display("FAIL pop_when_empty: got %0d pops while empty want 0", bad_pop);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
